// File: rtl/fixed_point_accumulate_if.sv
// fixed_point_accumulate_if
// Bundles the product stream (input side) and the saturated result stream
// (output side) of the sign-magnitude accumulator.
// master: the environment driving products and consuming results.
// slave : the accumulator itself.

interface fixed_point_accumulate_if #(
  parameter int BITSIZE   = 20,
  parameter int MAX_TERMS = 16
) ();

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // Product stream
  logic [BITSIZE-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [BITSIZE-1:0] bias;

  // Result stream
  logic [BITSIZE-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sat;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    output bias,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_sat,
    input  out_count
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    input  bias,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_sat,
    output out_count
  );

endinterface

// File: rtl/fixed_point_accumulate.sv
// fixed_point_accumulate
// Summing stage of a neuron dot product. Sign-magnitude product terms are
// converted to two's complement and added to a per-vector bias. The
// accumulator is wide enough that it can never overflow internally. One
// saturated sign-magnitude sum is produced per vector. A vector ends on
// in_last or when MAX_TERMS terms have been accepted, whichever comes first.

module fixed_point_accumulate #(
  parameter int BITSIZE   = 20,
  parameter int MAX_TERMS = 16,
  parameter int ACC_W     = BITSIZE + $clog2(MAX_TERMS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  fixed_point_accumulate_if.slave   io_bus
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // Term count at which a vector is closed regardless of in_last
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  // Largest magnitude representable in the sign-magnitude output
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((64'd1 << (BITSIZE - 1)) - 64'd1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Sign-magnitude to two's complement. Negative zero maps to zero because
  // negating a zero magnitude gives zero.
  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] sm);
    logic signed [ACC_W-1:0] mag;
    mag = signed'({{(ACC_W-BITSIZE+1){1'b0}}, sm[BITSIZE-2:0]});
    if (sm[BITSIZE-1]) begin
      sm_to_tc = -mag;
    end else begin
      sm_to_tc = mag;
    end
  endfunction

  // Two's complement to saturated sign-magnitude, returned as {sat, sm}.
  // A zero accumulator always produces a positive zero since acc<0 is false.
  function automatic logic [BITSIZE:0] tc_to_sm(input logic signed [ACC_W-1:0] acc);
    logic             neg;
    logic [ACC_W-1:0] mag;
    neg = acc[ACC_W-1];
    if (neg) begin
      mag = $unsigned(-acc);
    end else begin
      mag = $unsigned(acc);
    end
    if (mag > MAG_MAX) begin
      tc_to_sm = {1'b1, neg, {(BITSIZE-1){1'b1}}};
    end else begin
      tc_to_sm = {1'b0, neg, mag[BITSIZE-2:0]};
    end
  endfunction

  // State and datapath registers
  logic [1:0]              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic [BITSIZE-1:0]      r_out_data;
  logic                    r_out_valid;
  logic                    r_out_sat;
  logic [CNT_W-1:0]        r_out_count;

  // Combinational next-value signals
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_transfer;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_last_beat;
  logic [1:0]              w_state_next;
  logic [BITSIZE:0]        w_result;

  // Handshake qualifiers; in_ready is held low while reset is asserted
  always_comb begin
    w_in_ready = 1'b0;
    if (i_rst) begin
      w_in_ready = 1'b0;
    end else if (r_state == S_DONE) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = 1'b1;
    end
    w_accept   = io_bus.in_valid & w_in_ready;
    w_transfer = r_out_valid & io_bus.out_ready;
    w_term     = sm_to_tc(io_bus.in_data);
  end

  // Candidate sum, count and end-of-vector decision for the current beat
  always_comb begin
    w_sum       = r_acc;
    w_cnt_next  = r_count;
    w_last_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sum       = sm_to_tc(io_bus.bias) + w_term;
        w_cnt_next  = CNT_W'(1);
        w_last_beat = io_bus.in_last | (MAX_CNT == CNT_W'(1));
      end
      S_ACCUM: begin
        w_sum       = r_acc + w_term;
        w_cnt_next  = r_count + CNT_W'(1);
        w_last_beat = io_bus.in_last | (w_cnt_next == MAX_CNT);
      end
      default: begin
        w_sum       = r_acc;
        w_cnt_next  = r_count;
        w_last_beat = 1'b0;
      end
    endcase
    w_result = tc_to_sm(w_sum);
  end

  // Next-state selection for the IDLE/ACCUM/DONE controller
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_last_beat ? S_DONE : S_ACCUM;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_state_next = w_last_beat ? S_DONE : S_ACCUM;
        end else begin
          w_state_next = S_ACCUM;
        end
      end
      S_DONE: begin
        if (w_transfer) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, accumulator and result registers; results captured on entry to DONE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= w_cnt_next;
      end
      if (w_accept && w_last_beat) begin
        r_out_data  <= w_result[BITSIZE-1:0];
        r_out_sat   <= w_result[BITSIZE];
        r_out_count <= w_cnt_next;
        r_out_valid <= 1'b1;
      end else if (w_transfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sat   = r_out_sat;
  assign io_bus.out_count = r_out_count;

endmodule

// File: tb/tb_fixed_point_accumulate.sv
// tb_fixed_point_accumulate
// Directed and randomised vectors for the sign-magnitude accumulator.
// Expected results are queued as each vector is driven and checked when the
// accumulator presents its result.

module tb_fixed_point_accumulate;

  localparam int BITSIZE   = 20;
  localparam int MAX_TERMS = 16;

  typedef struct packed {
    logic [19:0] data;
    logic        sat;
    logic [4:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fixed_point_accumulate_if #(.BITSIZE(BITSIZE), .MAX_TERMS(MAX_TERMS)) bus ();

  fixed_point_accumulate #(.BITSIZE(BITSIZE), .MAX_TERMS(MAX_TERMS)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2int(input logic [19:0] v);
    int m;
    m = int'(v[18:0]);
    return v[19] ? -m : m;
  endfunction

  function automatic exp_t model_out(input int acc, input int cnt);
    exp_t e;
    int   mag;
    mag       = (acc < 0) ? -acc : acc;
    e.sat     = (mag > 524287);
    e.data[19] = (acc < 0);
    e.data[18:0] = e.sat ? 19'h7FFFF : mag[18:0];
    e.cnt     = cnt[4:0];
    return e;
  endfunction

  task automatic push(input logic [19:0] d, input logic s, input logic [4:0] c);
    exp_t e;
    e.data = d;
    e.sat  = s;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Present one beat (called at posedge+1) and hold it until accepted
  task automatic beat(input logic [19:0] d, input logic last, input logic [19:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.bias     = b;
    #1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Pop the next expected result and compare at the transfer
  task automatic expect_out(input string tag);
    exp_t e;
    int   n = 0;
    chk({tag, "_valid_latency"}, 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_data"},  32'(bus.out_data),  32'(e.data));
    chk({tag, "_sat"},   32'(bus.out_sat),   32'(e.sat));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(e.cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] terms [16];
    logic [31:0] r;
    logic [19:0] b;
    int          acc;
    int          n;

    bus.in_valid  = 1'b0;
    bus.in_data   = 20'h00000;
    bus.in_last   = 1'b0;
    bus.bias      = 20'h00000;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_sat",   32'(bus.out_sat),   32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic sum: 1.0 + 1.0 - 0.5
    push(20'h0C000, 1'b0, 5'd3);
    beat(20'h08000, 1'b0, 20'h00000);
    beat(20'h08000, 1'b0, 20'h00000);
    beat(20'h84000, 1'b1, 20'h00000);
    expect_out("basic");

    // Cancellation with a negative-zero bias
    push(20'h00000, 1'b0, 5'd2);
    beat(20'h08000, 1'b0, 20'h80000);
    beat(20'h88000, 1'b1, 20'h80000);
    expect_out("cancel");

    // Positive and negative saturation
    push(20'h7FFFF, 1'b1, 5'd2);
    beat(20'h7FFFF, 1'b0, 20'h00000);
    beat(20'h7FFFF, 1'b1, 20'h00000);
    expect_out("sat_pos");
    push(20'hFFFFF, 1'b1, 5'd2);
    beat(20'hFFFFF, 1'b0, 20'h00000);
    beat(20'hFFFFF, 1'b1, 20'h00000);
    expect_out("sat_neg");

    // Forced termination after MAX_TERMS beats; a 17th beat is refused
    push(20'h08000, 1'b0, 5'd16);
    for (int i = 0; i < 16; i++) beat(20'h00800, 1'b0, 20'h00000);
    chk("forced_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 20'h00800;
    bus.in_last  = 1'b0;
    expect_out("forced");
    bus.in_valid = 1'b0;

    // in_last coinciding with the MAX_TERMS-th beat terminates once
    push(20'h04000, 1'b0, 5'd16);
    for (int i = 0; i < 16; i++) beat(20'h00400, (i == 15), 20'h00000);
    expect_out("last_at_max");

    // Backpressure: result and in_ready hold while out_ready is low
    bus.out_ready = 1'b0;
    push(20'h01000, 1'b0, 5'd1);
    beat(20'h81000, 1'b1, 20'h02000);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_data",  32'(bus.out_data),  32'h01000);
      chk("bp_out_sat",   32'(bus.out_sat),   32'd0);
      chk("bp_out_count", 32'(bus.out_count), 32'd1);
      bus.in_valid = ~bus.in_valid;
      bus.in_data  = 20'h7FFFF;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    expect_out("bp");
    push(20'h00200, 1'b0, 5'd1);
    beat(20'h00100, 1'b1, 20'h00100);
    expect_out("after_bp");

    // Reset mid-vector discards the partial sum
    for (int i = 0; i < 3; i++) beat(20'h08000, 1'b0, 20'h00000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data",  32'(bus.out_data),  32'd0);
    chk("midrst_out_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;
    push(20'h08000, 1'b0, 5'd1);
    beat(20'h04000, 1'b1, 20'h04000);
    expect_out("after_rst");

    // Reset while a result is waiting
    bus.out_ready = 1'b0;
    beat(20'h08000, 1'b1, 20'h00000);
    chk("donerst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("donerst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("donerst_out_data",  32'(bus.out_data),  32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Random vectors checked against a behavioural integer model
    for (int v = 0; v < 6; v++) begin
      n = int'($urandom_range(16, 1));
      r = $urandom;
      b = r[19:0];
      acc = sm2int(b);
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        terms[i] = (v % 2 == 0) ? {r[19], 4'h0, r[14:0]} : r[19:0];
        acc += sm2int(terms[i]);
      end
      sb.push_back(model_out(acc, n));
      for (int i = 0; i < n; i++) beat(terms[i], (i == n - 1), b);
      expect_out("random");
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_point_accumulate.md
# fixed_point_accumulate

Sequential sign-magnitude accumulator directly downstream of the fixed-point multiplier. It consumes a stream of BITSIZE-bit sign-magnitude products (one per accepted beat), adds them to a per-vector bias, and emits one saturated sign-magnitude sum per vector. It is the summing stage of a neuron dot product. Its output feeds the activation stage.

## Interface
- BITSIZE, 20, word width; bit BITSIZE-1 is the sign, bits BITSIZE-2:0 are the magnitude (15 fractional bits; 1.0 = 20'h08000).
- MAX_TERMS, 16, maximum products per vector; the beat that brings the count to MAX_TERMS is forced to be the last.
- ACC_W, BITSIZE+$clog2(MAX_TERMS+1), internal two's-complement accumulator width (25 at defaults); sized so the accumulator never overflows internally.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  BITSIZE  sign-magnitude product term.
- in_valid  in  1  in_data is valid.
- in_last  in  1  the current beat is the final term of the vector.
- in_ready  out  1  the block accepts a beat this cycle (beat accepted = in_valid & in_ready).
- bias  in  BITSIZE  sign-magnitude bias, sampled only on the first beat of a vector.
- out_data  out  BITSIZE  saturated sign-magnitude sum.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data (transfer = out_valid & out_ready).
- out_sat  out  1  the result was clamped; qualified by out_valid.
- out_count  out  $clog2(MAX_TERMS+1)  number of terms in the result; qualified by out_valid.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- Term conversion: sign-magnitude to ACC_W two's complement. The magnitude is zero-extended, then negated if the sign is 1. Negative zero (sign 1, magnitude 0) converts to 0.
- IDLE: in_ready=1. On an accepted beat: acc <= conv(bias)+conv(in_data) and count <= 1. If in_last=1 or MAX_TERMS==1, go to DONE; otherwise go to ACCUM.
- ACCUM: in_ready=1. On an accepted beat: acc <= acc+conv(in_data) and count <= count+1. If in_last=1 or count+1==MAX_TERMS, go to DONE. With no beat, hold.
- DONE: in_ready=0. out_valid=1. out_data, out_sat and out_count are registered on entry and stay stable until transfer. On transfer, go to IDLE.
- Output conversion: sign = acc<0. mag = |acc|.
  - If mag > 2^(BITSIZE-1)-1: magnitude is all ones and out_sat=1.
  - Otherwise the magnitude is mag[BITSIZE-2:0] and out_sat=0.
  - acc==0 always yields sign 0.
- in_data, in_valid and in_last are ignored while in DONE. bias is ignored except on the first beat.

## Timing
- Reset values: state=IDLE, acc=0, count=0, out_data=0, out_valid=0, out_sat=0, out_count=0.
- in_ready is combinational from state: 1 in IDLE/ACCUM, 0 in DONE. in_ready is 0 during the reset cycle itself.
- Throughput: one term per cycle. No bubbles between beats within a vector.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Minimum vector period: N+1 cycles for N terms when out_ready=1. After a transfer the block is in IDLE and accepts a new first beat the next cycle.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold and in_ready=0.
- rst asserted in any state, including mid-ACCUM or DONE with out_valid=1: everything returns to reset values the next edge, and the partial sum is discarded.
- in_last=1 on a beat when count+1==MAX_TERMS: single termination, no double count.

## Test plan
- Basic sum: bias=20'h00000; terms 20'h08000, 20'h08000, 20'h84000 (last) → one cycle after the last beat: out_data=20'h0C000, out_sat=0, out_count=3.
- Cancellation and negative zero: bias=20'h80000; terms 20'h08000, 20'h88000 (last) → out_data=20'h00000, out_sat=0.
- Saturation:
  - bias=0; terms 20'h7FFFF, 20'h7FFFF (last) → out_data=20'h7FFFF, out_sat=1.
  - Same with 20'hFFFFF terms → out_data=20'hFFFFF, out_sat=1.
- Forced termination: 16 beats of 20'h00800 with in_last=0 → DONE after the 16th beat; out_data=20'h08000, out_count=16. The 17th beat is not accepted (in_ready=0).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 toggling → out_data/out_sat/out_count stable and in_ready=0 throughout. After out_ready=1, the next vector accumulates from its own bias only.
- Reset mid-vector: 3 beats of 20'h08000, then rst for 1 cycle → outputs at reset values. A new vector (bias 20'h04000, term 20'h04000 last) yields 20'h08000.
